sqrt_result_checker: RTL and testbench
======================================

// Module: sqrt_result_checker
// PURPOSE
//  - Inverse/consumer end of the square-root pipeline: accepts (input, root) result pairs, re-squares root
//    with a sequential shift-add multiplier, and checks root^2 <= input < (root+1)^2.
//  - Sits after the pipeline output stage; used in-system as a self-check and by benches as a scoreboard front end.
// PARAMETERS
//  - ROOT_WIDTH  8   root width; input width is 2*ROOT_WIDTH, square width 2*ROOT_WIDTH+1
//  - CNT_WIDTH   16  error counter width (only meaningful with SQRT_CHK_ERRCNT_EN)
// PORTS
//  - clk          in   1   single clock, rising edge
//  - rst_n        in   1   asynchronous active-low reset
//  - in_valid_i   in   1   input pair valid
//  - in_ready_o   out  1   checker can accept a pair
//  - input_i      in   16  radicand
//  - root_i       in   8   claimed integer square root
//  - res_valid_o  out  1   result valid
//  - res_ready_i  in   1   result consumer ready
//  - pass_o       out  1   1 = root correct
//  - square_o     out  17  (root+1)^2, registered with result
//  - err_clr_i    in   1   synchronous clear of error counter
//  - err_count_o  out  16  saturating count of failed results (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; in_ready_o=1, res_valid_o=0, pass_o=0, square_o=0, err_count_o=0.
//  - FSM IDLE/MUL/CMP/DONE. IDLE: in_ready_o=1; on in_valid_i&in_ready_o capture input_i, root_i; acc=0, bit=0 -> MUL.
//  - MUL: one root bit per cycle, LSB first: if root[bit] acc += root<<bit; after bit ROOT_WIDTH-1 -> CMP.
//  - CMP: sq_lo=acc; sq_hi=acc+(root<<1)+1 (17 bit, no overflow: max 65536); pass = (sq_lo<=input)&&(input<sq_hi);
//    register pass_o, square_o=sq_hi -> DONE.
//  - DONE: res_valid_o=1; pass_o/square_o held stable until res_ready_i; on handshake -> IDLE.
//  - Latency: res_valid_o high ROOT_WIDTH+1 cycles after accept edge (9 for default). in_ready_o=0 in MUL/CMP/DONE;
//    no accept in the result-handshake cycle; peak throughput one pair per ROOT_WIDTH+3 cycles.
//  - in_valid_i during busy: ignored, producer must hold (valid/ready rule: data stable while valid&&!ready).
//  - Reset mid-operation discards in-flight pair; no partial result ever presented.
//  - All arithmetic unsigned; acc is 2*ROOT_WIDTH bits, compare done at 17 bits.
// CONFIGURATION
//  - SQRT_CHK_ERRCNT_EN defined: err_count_o increments on result handshake with pass_o=0, saturates at all-ones;
//    err_clr_i zeroes it next edge; clear and increment in same cycle -> clear wins (0).
//  - Not defined: counter not built, err_count_o tied 0, err_clr_i ignored.
// STRUCTURE
//  - Shared package sqrt_pkg: ROOT_W=8, IN_W=16, SQ_W=17 constants, state encoding localparams.
//  - One sub-module seq_squarer (start/done, shift-add over ROOT_WIDTH cycles, 16-bit product); FSM and compare
//    stay in top. State/result registers use the codebase gen_reg/dffa with enable.
// TESTING
//  - input=144, root=12 -> after 9 cycles res_valid_o=1, pass_o=1, square_o=169.
//  - input=169, root=12 -> pass_o=0, square_o=169; err_count_o 0->1 on handshake (with EN).
//  - input=65535, root=255 -> pass_o=1, square_o=65536 (bit 16 set); input=0, root=0 -> pass_o=1, square_o=1.
//  - res_ready_i low 5 cycles in DONE -> pass_o/square_o stable, in_ready_o=0, second in_valid_i not accepted.
//  - rst_n low during MUL -> res_valid_o=0 immediately, in_ready_o=1, next pair 100/10 -> pass_o=1, square_o=121.
//  - With EN: preload 0xFFFF via failures/force, another fail -> stays 0xFFFF; err_clr_i with fail handshake -> 0.

Source files
------------

// File: rtl/sqrt_result_checker_pkg.sv
// Shared constants and FSM encoding for the square-root result checker.
// Imported by seq_squarer and sqrt_result_checker.
package sqrt_pkg;

    localparam int ROOT_W = 8;
    localparam int IN_W   = 16;
    localparam int SQ_W   = 17;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sqrt_result_checker_squarer.sv
// Sequential shift-add squarer: one operand bit per cycle, LSB first.
// done is high during the cycle whose edge completes the product.
module seq_squarer #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   operand,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LAST = BW'(W - 1);

    logic [W-1:0]   op;
    logic [2*W-1:0] acc;
    logic [BW-1:0]  idx;
    logic           busy;

    assign done    = busy && (idx == LAST);
    assign product = acc;

    // load on start, then add the shifted operand for every set bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op   <= '0;
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            op   <= operand;
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (op[idx]) begin
                acc <= acc + ({{W{1'b0}}, op} << idx);
            end
            idx <= idx + 1'b1;
            if (idx == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sqrt_result_checker.sv
// Checks (input, root) pairs: root^2 <= input < (root+1)^2.
// Optional error counter enabled by defining SQRT_CHK_ERRCNT_EN.
module sqrt_result_checker
    import sqrt_pkg::*;
#(
    parameter int ROOT_WIDTH = ROOT_W,
    parameter int CNT_WIDTH  = CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2*ROOT_WIDTH-1:0] input_i,
    input  logic [ROOT_WIDTH-1:0] root_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  pass_o,
    output logic [2*ROOT_WIDTH:0] square_o,
    input  logic                  err_clr_i,
    output logic [CNT_WIDTH-1:0]  err_count_o
);

    localparam int IW = 2 * ROOT_WIDTH;
    localparam int SW = 2 * ROOT_WIDTH + 1;

    state_t state, state_nxt;

    logic [IW-1:0]         in_q;
    logic [ROOT_WIDTH-1:0] root_q;
    logic [IW-1:0]         product;
    logic                  sq_done;
    logic                  in_fire;
    logic                  res_fire;
    logic [SW-1:0]         sq_lo;
    logic [SW-1:0]         sq_hi;
    logic [SW-1:0]         in_ext;
    logic                  pass_c;

    assign in_fire  = in_valid_i && in_ready_o;
    assign res_fire = res_valid_o && res_ready_i;

    seq_squarer #(
        .W (ROOT_WIDTH)
    ) u_sq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (in_fire),
        .operand (root_i),
        .done    (sq_done),
        .product (product)
    );

    // (root+1)^2 = root^2 + 2*root + 1; fits in SW bits by construction
    assign sq_lo  = {1'b0, product};
    assign sq_hi  = sq_lo + SW'({root_q, 1'b1});
    assign in_ext = {1'b0, in_q};
    assign pass_c = (sq_lo <= in_ext) && (in_ext < sq_hi);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nxt = ST_MUL;
            end
            ST_MUL: begin
                if (sq_done) state_nxt = ST_CMP;
            end
            ST_CMP: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) state_nxt = ST_IDLE;
            end
        endcase
    end

    // capture the pair on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q   <= '0;
            root_q <= '0;
        end else if (in_fire) begin
            in_q   <= input_i;
            root_q <= root_i;
        end
    end

    // result registers, held until the next compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_o   <= 1'b0;
            square_o <= '0;
        end else if (state == ST_CMP) begin
            pass_o   <= pass_c;
            square_o <= sq_hi;
        end
    end

`ifdef SQRT_CHK_ERRCNT_EN
    logic [CNT_WIDTH-1:0] err_cnt;

    // saturating failure count; clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr_i) begin
            err_cnt <= '0;
        end else if (res_fire && !pass_o && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign err_count_o = err_cnt;
`else
    logic unused_err;

    assign unused_err  = err_clr_i ^ res_fire;
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_sqrt_result_checker.sv
// Randomized bench for sqrt_result_checker with an arithmetic reference
// model plus directed pairs with literal expectations.
module tb_sqrt_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic [7:0]  root;
    logic        res_valid;
    logic        res_ready;
    logic        pass;
    logic [16:0] square;
    logic        err_clr;
    logic [15:0] err_count;

    int tests = 0;
    int fails = 0;

    bit          checking = 0;
    bit          m_idle;
    bit          m_valid;
    bit          m_pass;
    bit          m_acc;
    int          m_cnt;
    logic [16:0] m_sq;
    logic [15:0] m_err;
    logic [15:0] m_in;
    logic [7:0]  m_root;

`ifdef SQRT_CHK_ERRCNT_EN
    localparam logic [15:0] ERR_AFTER_FAIL = 16'd1;
`else
    localparam logic [15:0] ERR_AFTER_FAIL = 16'd0;
`endif

    sqrt_result_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .input_i     (din),
        .root_i      (root),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .pass_o      (pass),
        .square_o    (square),
        .err_clr_i   (err_clr),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit ref_pass(input int a, input int r);
        return (r * r <= a) && (a < (r + 1) * (r + 1));
    endfunction

    task automatic model_reset();
        m_idle  = 1;
        m_valid = 0;
        m_pass  = 0;
        m_sq    = '0;
        m_err   = '0;
        m_cnt   = 0;
        m_acc   = 0;
    endtask

    // advance the model across one rising edge using the inputs seen there
    task automatic model_step();
        bit hs;
        m_acc = 0;
        if (!rst_n) return;
        hs = m_valid && res_ready;
`ifdef SQRT_CHK_ERRCNT_EN
        if (err_clr) m_err = '0;
        else if (hs && !m_pass && m_err != 16'hFFFF) m_err = m_err + 1'b1;
`endif
        if (m_idle && in_valid) begin
            m_idle = 0;
            m_acc  = 1;
            m_in   = din;
            m_root = root;
            m_cnt  = 9;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1;
                m_pass  = ref_pass(int'(m_in), int'(m_root));
                m_sq    = 17'((int'(m_root) + 1) * (int'(m_root) + 1));
            end
        end else if (hs) begin
            m_valid = 0;
            m_idle  = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", in_ready, m_idle);
            chk("res_valid", res_valid, m_valid);
            chk("pass", pass, m_pass);
            chk("square", square, m_sq);
            chk("err_count", err_count, m_err);
        end
    end

    task automatic do_pair(input logic [15:0] a, input logic [7:0] r,
                           input int stall, input bit clr,
                           input bit expp, input logic [16:0] exps);
        int n;
        int lat;
        n = 0;
        while (!m_idle && n < 40) begin
            step();
            n++;
        end
        chk("idle_wait", in_ready, 1);
        in_valid = 1;
        din      = a;
        root     = r;
        step();
        in_valid = 0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, 9);
        chk("lit_pass", pass, expp);
        chk("lit_square", square, exps);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1;
            din      = 16'($urandom);
            root     = 8'($urandom);
            step();
            chk("stall_pass", pass, expp);
            chk("stall_square", square, exps);
            chk("stall_ready", in_ready, 0);
        end
        in_valid  = 0;
        res_ready = 1;
        err_clr   = clr;
        step();
        res_ready = 0;
        err_clr   = 0;
    endtask

    initial begin
        int r;
        int mode;
        int v;
        in_valid  = 0;
        din       = '0;
        root      = '0;
        res_ready = 0;
        err_clr   = 0;
        rst_n     = 1;
        model_reset();
        #2;
        rst_n = 0;
        model_reset();
        checking = 1;
        step();
        step();
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", res_valid, 0);
        chk("rst_square", square, 0);
        rst_n = 1;

        do_pair(16'd144, 8'd12, 0, 0, 1'b1, 17'd169);
        do_pair(16'd169, 8'd12, 0, 0, 1'b0, 17'd169);
        chk("err_after_fail", err_count, ERR_AFTER_FAIL);
        do_pair(16'd65535, 8'd255, 0, 0, 1'b1, 17'h10000);
        do_pair(16'd0, 8'd0, 5, 0, 1'b1, 17'd1);

        // reset in the middle of the multiply
        in_valid = 1;
        din      = 16'd50;
        root     = 8'd7;
        step();
        in_valid = 0;
        step();
        step();
        step();
        rst_n = 0;
        model_reset();
        #1;
        chk("midrst_valid", res_valid, 0);
        chk("midrst_ready", in_ready, 1);
        step();
        rst_n = 1;
        do_pair(16'd100, 8'd10, 0, 0, 1'b1, 17'd121);

`ifdef SQRT_CHK_ERRCNT_EN
        @(posedge clk);
        #1;
        model_step();
        force dut.err_cnt = 16'hFFFF;
        #1;
        release dut.err_cnt;
        m_err = 16'hFFFF;
        do_pair(16'd169, 8'd12, 0, 0, 1'b0, 17'd169);
        chk("err_sat", err_count, 16'hFFFF);
        do_pair(16'd169, 8'd12, 0, 1, 1'b0, 17'd169);
        chk("err_clr", err_count, 16'h0000);
`endif

        // randomized traffic around the square boundaries
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || m_acc) begin
                in_valid = ($urandom % 3) != 0;
                r        = int'($urandom % 256);
                mode     = int'($urandom % 5);
                case (mode)
                    0: v = r * r;
                    1: v = (r + 1) * (r + 1) - 1;
                    2: v = (r + 1) * (r + 1);
                    3: v = r * r - 1;
                    default: v = int'($urandom);
                endcase
                root = 8'(r);
                din  = 16'(v);
            end
            res_ready = $urandom % 2;
            err_clr   = ($urandom % 16) == 0;
            step();
        end
        in_valid  = 0;
        res_ready = 1;
        err_clr   = 0;
        repeat (30) step();

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
